// File: rtl/fifo_rd_drain_pkg.sv
// fifo_pkg: shared constants and types for the FIFO read-side drain.
package fifo_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_FRAME_LEN = 64;
    localparam int DEF_CNT_W     = 16;

    // Output buffer depth: one entry for the word in flight, one for the
    // word being presented downstream.
    localparam int BUF_DEPTH = 2;
    localparam int PTR_W     = $clog2(BUF_DEPTH);
    localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

    typedef enum logic [0:0] {
        ST_DATA = 1'b0,
        ST_CSUM = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_rd_drain_if.sv
// fifo_rd_drain_if: FIFO read port plus the framed valid/ready output stream.
// master = the drain (pops the FIFO, drives the stream), slave = its environment.
interface fifo_rd_drain_if #(
    parameter int DATA_W = fifo_pkg::DEF_DATA_W,
    parameter int CNT_W  = fifo_pkg::DEF_CNT_W
);
    logic [DATA_W-1:0] fifo_rd_data;
    logic              fifo_empty;
    logic              fifo_rd_en;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic [CNT_W-1:0]  frames_done;

    modport master (
        input  fifo_rd_data, fifo_empty, out_ready,
        output fifo_rd_en, out_data, out_valid, out_last, frames_done
    );

    modport slave (
        output fifo_rd_data, fifo_empty, out_ready,
        input  fifo_rd_en, out_data, out_valid, out_last, frames_done
    );
endinterface

// File: rtl/fifo_rd_drain_skid_buf.sv
// fifo_skid_buf: 2-entry FIFO-ordered buffer absorbing the FIFO read latency.
// Simultaneous push and pop are allowed; the caller guarantees no overflow
// (credit) and no underflow (pop only while occ>0).
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [OCC_W-1:0]  occ
);

    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // Storage, pointers and occupancy; reset clears the contents so the head
    // word reads as zero out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_drain.sv
// fifo_rd_drain: read-domain consumer of the async FIFO. Pops on credit,
// buffers through fifo_skid_buf, emits a framed valid/ready stream.
// Optional feature: define FIFO_DRAIN_CHECKSUM_EN to append a per-frame
// modulo-2^DATA_W checksum word (carrying out_last) after every FRAME_LEN words.
module fifo_rd_drain
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic            rd_clk,
    input  logic            rd_rst_n,
    fifo_rd_drain_if.master bus
);

    localparam int              WC_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(FRAME_LEN - 1);

    logic [OCC_W-1:0]  occ;
    logic [DATA_W-1:0] head;
    logic              inflight;
    logic              xfer;
    logic              pop;
    logic [2:0]        used;
    logic [WC_W-1:0]   wcnt;
    logic [CNT_W-1:0]  frames_q;

    fifo_skid_buf #(.DATA_W(DATA_W)) u_buf (
        .clk       (rd_clk),
        .rst_n     (rd_rst_n),
        .push      (inflight),
        .push_data (bus.fifo_rd_data),
        .pop       (pop),
        .head      (head),
        .occ       (occ)
    );

    assign xfer = bus.out_valid && bus.out_ready;

    // Credit: slots committed after this edge = buffered + in flight - leaving.
    // pop implies occ>0, so the subtraction cannot wrap. Gated by rd_rst_n so
    // no pop is requested while the FIFO read side is held in reset.
    assign used           = 3'(occ) + 3'(inflight) - 3'(pop);
    assign bus.fifo_rd_en = rd_rst_n && !bus.fifo_empty && (used < 3'(BUF_DEPTH));

    // Remembers an accepted pop so its data is written into the buffer next edge.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) inflight <= 1'b0;
        else           inflight <= bus.fifo_rd_en;
    end

    assign bus.frames_done = frames_q;

`ifdef FIFO_DRAIN_CHECKSUM_EN
    state_e            state;
    logic [DATA_W-1:0] csum;

    assign bus.out_valid = (state == ST_CSUM) || (occ != '0);
    assign bus.out_data  = (state == ST_CSUM) ? csum : head;
    assign bus.out_last  = (state == ST_CSUM);
    assign pop           = xfer && (state == ST_DATA);

    // Framing FSM: count data words and accumulate their sum, then spend one
    // output cycle on the checksum word; frame completes on its transfer.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state    <= ST_DATA;
            wcnt     <= '0;
            csum     <= '0;
            frames_q <= '0;
        end else if (xfer) begin
            case (state)
                ST_DATA: begin
                    csum <= csum + head;
                    if (wcnt == WC_LAST) begin
                        wcnt  <= '0;
                        state <= ST_CSUM;
                    end else begin
                        wcnt <= wcnt + WC_W'(1);
                    end
                end
                default: begin
                    state    <= ST_DATA;
                    csum     <= '0;
                    frames_q <= frames_q + CNT_W'(1);
                end
            endcase
        end
    end
`else
    assign bus.out_valid = (occ != '0);
    assign bus.out_data  = head;
    assign bus.out_last  = (wcnt == WC_LAST);
    assign pop           = xfer;

    // Framing counter: the FRAME_LEN-th data word carries out_last and
    // completes the frame on its transfer.
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            wcnt     <= '0;
            frames_q <= '0;
        end else if (xfer) begin
            if (wcnt == WC_LAST) begin
                wcnt     <= '0;
                frames_q <= frames_q + CNT_W'(1);
            end else begin
                wcnt <= wcnt + WC_W'(1);
            end
        end
    end
`endif

endmodule
